// File: rtl/gpr_file_scoreboard.sv
// Register file with two write ports, same-cycle write-to-read bypass and a
// per-register busy scoreboard used by issue logic to stall on late results.
module gpr_file_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr,
  output logic [ADDR_W:0]            busy_cnt,
  output logic [1:0]                 err_flags
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busyNext;
  logic [CNT_W-1:0]  busyCntNext;
  logic              wr0Valid;
  logic              wr1Valid;
  logic              claimValid;
  logic              cntInc;
  logic              cntDec;

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] addr);
    return (ZERO_REG != 0) && (addr == '0);
  endfunction

  assign wr0Valid   = wr0_en && !isZeroReg(wr0_addr);
  assign wr1Valid   = wr1_en && !isZeroReg(wr1_addr);
  assign claimValid = claim_en && !isZeroReg(claim_addr);

  // wr1 is applied last so it wins a same-address collision with wr0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wr0Valid) begin
        regs[wr0_addr] <= wr0_data;
      end
      if (wr1Valid) begin
        regs[wr1_addr] <= wr1_data;
      end
    end
  end

  // Claim is applied after the clear so a same-index claim keeps the bit set;
  // the counter moves only on real 0->1 / 1->0 transitions of the busy bits.
  always_comb begin
    busyNext = busy;
    if (wr1Valid) begin
      busyNext[wr1_addr] = 1'b0;
    end
    if (claimValid) begin
      busyNext[claim_addr] = 1'b1;
    end
    cntInc = claimValid && !busy[claim_addr];
    cntDec = wr1Valid && busy[wr1_addr] && !(claimValid && (claim_addr == wr1_addr));
    busyCntNext = busy_cnt;
    if (cntInc && !cntDec) begin
      busyCntNext = busy_cnt + CNT_W'(1);
    end else if (cntDec && !cntInc) begin
      busyCntNext = busy_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy      <= '0;
      busy_cnt  <= '0;
      err_flags <= 2'b00;
    end else begin
      busy     <= busyNext;
      busy_cnt <= busyCntNext;
      if (wr0Valid && wr1Valid && (wr0_addr == wr1_addr)) begin
        err_flags[0] <= 1'b1;
      end
      if (wr0Valid && busy[wr0_addr]) begin
        err_flags[1] <= 1'b1;
      end
    end
  end

  // Read ports: zero register, then wr1 bypass, then wr0 bypass, then storage.
  always_comb begin
    logic [ADDR_W-1:0] portAddr;
    portAddr = '0;
    rd_data  = '0;
    rd_busy  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      portAddr = rd_addr[k*ADDR_W +: ADDR_W];
      if (isZeroReg(portAddr)) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end else if (wr1_en && (wr1_addr == portAddr)) begin
        rd_data[k*DATA_W +: DATA_W] = wr1_data;
      end else if (wr0_en && (wr0_addr == portAddr)) begin
        rd_data[k*DATA_W +: DATA_W] = wr0_data;
      end else begin
        rd_data[k*DATA_W +: DATA_W] = regs[portAddr];
      end
      rd_busy[k] = busy[portAddr] && !(wr1_en && (wr1_addr == portAddr));
    end
  end

endmodule

// File: tb/tb_gpr_file_scoreboard.sv
// Self-checking bench for gpr_file_scoreboard: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
module tb_gpr_file_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 4;
  localparam int DEPTH  = 32;

  logic                     clock;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rdAddr;
  logic [NUM_RD*DATA_W-1:0] rdData;
  logic [NUM_RD-1:0]        rdBusy;
  logic                     wr0En;
  logic [ADDR_W-1:0]        wr0Addr;
  logic [DATA_W-1:0]        wr0Data;
  logic                     wr1En;
  logic [ADDR_W-1:0]        wr1Addr;
  logic [DATA_W-1:0]        wr1Data;
  logic                     claimEn;
  logic [ADDR_W-1:0]        claimAddr;
  logic [ADDR_W:0]          busyCnt;
  logic [1:0]               errFlags;

  logic [DATA_W-1:0] modelRegs [DEPTH];
  bit                modelBusy [DEPTH];
  logic [1:0]        modelErr;
  int                checks;
  int                errors;

  gpr_file_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)
  ) dut (
    .clock(clock), .reset(reset),
    .rd_addr(rdAddr), .rd_data(rdData), .rd_busy(rdBusy),
    .wr0_en(wr0En), .wr0_addr(wr0Addr), .wr0_data(wr0Data),
    .wr1_en(wr1En), .wr1_addr(wr1Addr), .wr1_data(wr1Data),
    .claim_en(claimEn), .claim_addr(claimAddr),
    .busy_cnt(busyCnt), .err_flags(errFlags)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] expectedRead(input logic [ADDR_W-1:0] a);
    if (a == 0) return '0;
    if (wr1En && wr1Addr == a) return wr1Data;
    if (wr0En && wr0Addr == a) return wr0Data;
    return modelRegs[a];
  endfunction

  function automatic bit expectedBusy(input logic [ADDR_W-1:0] a);
    return modelBusy[a] && !(wr1En && wr1Addr == a);
  endfunction

  function automatic int modelCount();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(modelBusy[i]);
    return n;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      modelRegs[i] = '0;
      modelBusy[i] = 1'b0;
    end
    modelErr = 2'b00;
  endtask

  // Applies one clock edge of the specified write/claim semantics to the model.
  task automatic updateModel();
    bit w0;
    bit w1;
    w0 = wr0En && (wr0Addr != 0);
    w1 = wr1En && (wr1Addr != 0);
    if (w0 && modelBusy[wr0Addr]) modelErr[1] = 1'b1;
    if (w0 && w1 && wr0Addr == wr1Addr) modelErr[0] = 1'b1;
    if (w0) modelRegs[wr0Addr] = wr0Data;
    if (w1) modelRegs[wr1Addr] = wr1Data;
    if (w1) modelBusy[wr1Addr] = 1'b0;
    if (claimEn && claimAddr != 0) modelBusy[claimAddr] = 1'b1;
  endtask

  task automatic checkAll(input string phase);
    for (int k = 0; k < NUM_RD; k++) begin
      checkOutput($sformatf("%s.data%0d", phase, k), 64'(rdData[k*DATA_W +: DATA_W]),
                  64'(expectedRead(rdAddr[k*ADDR_W +: ADDR_W])));
      checkOutput($sformatf("%s.busy%0d", phase, k), 64'(rdBusy[k]),
                  64'(expectedBusy(rdAddr[k*ADDR_W +: ADDR_W])));
    end
    checkOutput({phase, ".busyCnt"}, 64'(busyCnt), 64'(modelCount()));
    checkOutput({phase, ".errFlags"}, 64'(errFlags), 64'(modelErr));
  endtask

  task automatic applyStimulus(input string phase);
    #1;
    checkAll(phase);
    @(posedge clock);
    updateModel();
    @(negedge clock);
  endtask

  task automatic clearInputs();
    wr0En = 0; wr0Addr = '0; wr0Data = '0;
    wr1En = 0; wr1Addr = '0; wr1Data = '0;
    claimEn = 0; claimAddr = '0;
  endtask

  task automatic setRead(input int k, input logic [ADDR_W-1:0] a);
    rdAddr[k*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("rst.busyCnt", 64'(busyCnt), 64'd0);
    checkOutput("rst.errFlags", 64'(errFlags), 64'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    rdAddr = '0;
    clearInputs();
    modelReset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("init.busyCnt", 64'(busyCnt), 64'd0);

    // Asynchronous reset in the middle of a cycle wipes data and claims.
    wr0En = 1; wr0Addr = 5; wr0Data = 32'hDEADBEEF;
    claimEn = 1; claimAddr = 7;
    applyStimulus("t1.write");
    clearInputs();
    setRead(0, 5);
    #1;
    checkOutput("t1.preData", 64'(rdData[31:0]), 64'hDEADBEEF);
    checkOutput("t1.preCnt", 64'(busyCnt), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t1.rstData", 64'(rdData[31:0]), 64'd0);
    checkOutput("t1.rstCnt", 64'(busyCnt), 64'd0);
    checkOutput("t1.rstErr", 64'(errFlags), 64'd0);
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Same-cycle bypass and zero register.
    wr0En = 1; wr0Addr = 3; wr0Data = 32'h12345678;
    setRead(0, 3);
    #1;
    checkOutput("t2.bypass", 64'(rdData[31:0]), 64'h12345678);
    applyStimulus("t2.write");
    clearInputs();
    #1;
    checkOutput("t2.stored", 64'(rdData[31:0]), 64'h12345678);
    applyStimulus("t2.after");
    wr0En = 1; wr0Addr = 0; wr0Data = 32'hFFFFFFFF;
    setRead(1, 0);
    #1;
    checkOutput("t2.zeroBypass", 64'(rdData[63:32]), 64'd0);
    applyStimulus("t2.zeroWrite");
    clearInputs();
    #1;
    checkOutput("t2.zeroStored", 64'(rdData[63:32]), 64'd0);
    applyStimulus("t2.zeroAfter");

    // Claim becomes visible next cycle; a late-return clear is visible at once.
    claimEn = 1; claimAddr = 8;
    setRead(0, 8);
    #1;
    checkOutput("t3.claimSameCycle", 64'(rdBusy[0]), 64'd0);
    applyStimulus("t3.claim");
    clearInputs();
    #1;
    checkOutput("t3.busyNext", 64'(rdBusy[0]), 64'd1);
    checkOutput("t3.cntNext", 64'(busyCnt), 64'd1);
    applyStimulus("t3.wait0");
    applyStimulus("t3.wait1");
    applyStimulus("t3.wait2");
    wr1En = 1; wr1Addr = 8; wr1Data = 32'hCAFE0001;
    #1;
    checkOutput("t3.clearBusy", 64'(rdBusy[0]), 64'd0);
    checkOutput("t3.clearData", 64'(rdData[31:0]), 64'hCAFE0001);
    applyStimulus("t3.wr1");
    clearInputs();
    #1;
    checkOutput("t3.cntAfter", 64'(busyCnt), 64'd0);
    applyStimulus("t3.after");

    // Claim and clear of the same register: claim wins, data still written.
    claimEn = 1; claimAddr = 9;
    wr1En = 1; wr1Addr = 9; wr1Data = 32'h55;
    applyStimulus("t4.both");
    clearInputs();
    setRead(0, 9);
    #1;
    checkOutput("t4.data", 64'(rdData[31:0]), 64'h55);
    checkOutput("t4.busy", 64'(rdBusy[0]), 64'd1);
    checkOutput("t4.cnt", 64'(busyCnt), 64'd1);
    applyStimulus("t4.after");

    // Write collision, then WAW on a busy register; both flags stay sticky.
    wr0En = 1; wr0Addr = 4; wr0Data = 32'h1;
    wr1En = 1; wr1Addr = 4; wr1Data = 32'h2;
    applyStimulus("t5.collide");
    clearInputs();
    setRead(0, 4);
    #1;
    checkOutput("t5.collideData", 64'(rdData[31:0]), 64'h2);
    checkOutput("t5.collideErr", 64'(errFlags), 64'b01);
    claimEn = 1; claimAddr = 6;
    applyStimulus("t5.claim");
    clearInputs();
    wr0En = 1; wr0Addr = 6; wr0Data = 32'h7;
    applyStimulus("t5.waw");
    clearInputs();
    setRead(0, 6);
    #1;
    checkOutput("t5.wawData", 64'(rdData[31:0]), 64'h7);
    checkOutput("t5.wawErr", 64'(errFlags), 64'b11);
    for (int i = 0; i < 3; i++) applyStimulus("t5.hold");
    #1;
    checkOutput("t5.sticky", 64'(errFlags), 64'b11);

    // Fill the scoreboard; the counter saturates naturally at 31.
    pulseReset();
    for (int i = 1; i < DEPTH; i++) begin
      claimEn = 1; claimAddr = ADDR_W'(i);
      applyStimulus("t6.fill");
    end
    clearInputs();
    #1;
    checkOutput("t6.full", 64'(busyCnt), 64'd31);
    claimEn = 1; claimAddr = 1;
    applyStimulus("t6.reclaim");
    clearInputs();
    for (int k = 0; k < NUM_RD; k++) setRead(k, ADDR_W'(k + 1));
    #1;
    checkOutput("t6.reclaimCnt", 64'(busyCnt), 64'd31);
    checkOutput("t6.allBusy", 64'(rdBusy), 64'hF);
    applyStimulus("t6.after");

    // Randomized traffic, concentrated on a few registers to force overlaps.
    pulseReset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc % 200 == 199) pulseReset();
      wr0En     = ($urandom_range(0, 2) == 0);
      wr0Addr   = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      wr0Data   = $urandom;
      wr1En     = ($urandom_range(0, 2) == 0);
      wr1Addr   = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      wr1Data   = $urandom;
      claimEn   = ($urandom_range(0, 1) == 0);
      claimAddr = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      for (int k = 0; k < NUM_RD; k++) begin
        setRead(k, ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom));
      end
      applyStimulus("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_file_scoreboard.md
Name: gpr_file_scoreboard

Overview:
Parametrised successor to the core's general-purpose register file. Provides NUM_RD combinational read ports and two write ports:
- wr0: in-order writeback.
- wr1: late-return path, e.g. load or mult/div.

Adds same-cycle write-to-read bypass and a per-register pending (busy) scoreboard so issue logic can stall on outstanding long-latency results. Sits between decode (reads, claims) and the writeback stages.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero, is never written and is never busy

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
rd_addr  input  NUM_RD*ADDR_W  packed read indices; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  packed read data, combinational
rd_busy  output  NUM_RD  per-port: addressed register has a pending result
wr0_en  input  1  primary write enable
wr0_addr  input  ADDR_W  primary write index
wr0_data  input  DATA_W  primary write data
wr1_en  input  1  late-return write enable; also clears the busy bit
wr1_addr  input  ADDR_W  late-return write index
wr1_data  input  DATA_W  late-return write data
claim_en  input  1  mark claim_addr pending (sets its busy bit)
claim_addr  input  ADDR_W  register being claimed
busy_cnt  output  ADDR_W+1  number of busy registers (registered)
err_flags  output  2  sticky errors: [0] wr0/wr1 same-address collision, [1] wr0 to a busy register

Behaviour:
- Reset (asynchronous, while high):
  - All registers, busy bits, busy_cnt and err_flags are cleared to 0.
  - rd_data therefore reads 0 and rd_busy reads 0.
  - Reset mid-operation discards all pending claims.
- Writes on the rising clock edge:
  - When ZERO_REG=1, writes to index 0 are ignored.
  - When wr0 and wr1 target the same index in one cycle, wr1 data is stored and err_flags[0] is set.
- Read path, per port k (combinational, zero latency):
  - If ZERO_REG=1 and addr=0, the result is 0.
  - Otherwise, if wr1_en and wr1_addr matches (and is not the zero register), the result is wr1_data.
  - Otherwise, if wr0_en and wr0_addr matches (and is not the zero register), the result is wr0_data.
  - Otherwise the result is the stored value.
- Scoreboard, on the clock edge:
  - claim_en sets busy[claim_addr]; a claim of index 0 is ignored when ZERO_REG=1.
  - wr1_en clears busy[wr1_addr].
  - Claim and clear of the same index in one cycle: claim wins, busy stays 1.
  - Claiming an already-busy register: busy stays 1 and busy_cnt is unchanged; this is not an error.
  - wr0_en to a register whose busy bit is 1: data is written, busy is unchanged, err_flags[1] is set (WAW hazard).
  - wr1_en to a non-busy register: data is written normally, no error.
- rd_busy[k] = busy[addr_k] AND NOT (wr1_en AND wr1_addr == addr_k).
  - A clear is visible in the same cycle.
  - A claim becomes visible the next cycle.
- busy_cnt is registered and always equals the population count of the busy bits.
  - It is updated by +1, 0 or -1 per cycle according to the net set/clear.
  - Range is 0..2**ADDR_W (minus 1 when ZERO_REG=1); it never wraps.
- err_flags bits are sticky until reset.
- Any number of read ports may address the same register simultaneously; all return identical data.

Test Plan:
1. Assert reset asynchronously mid-cycle after writing 0xDEADBEEF to r5 -> rd_data for r5 reads 0 immediately; busy_cnt=0; err_flags=0.
2. wr0 r3=0x12345678 with rd_addr port0=r3 in the same cycle -> port0 shows 0x12345678 before the edge and after it. A write to r0 -> r0 still reads 0.
3. claim r8 at cycle 1 -> rd_busy=1 and busy_cnt=1 from cycle 2. wr1 r8=0xCAFE0001 at cycle 5 -> rd_busy=0 and data=0xCAFE0001 during cycle 5; busy_cnt=0 at cycle 6.
4. Same cycle: claim r9 and wr1 r9=0x55 -> r9=0x55 stored, busy[r9] remains 1, busy_cnt incremented by 1.
5. wr0 r4=0x1 and wr1 r4=0x2 in one cycle -> r4=0x2 and err_flags[0]=1. Then claim r6 and wr0 r6=0x7 -> r6=0x7 and err_flags=2'b11, held until reset.
6. Claim r1..r31 on consecutive cycles -> busy_cnt reaches 31 and does not wrap. Re-claim r1 -> busy_cnt stays 31. NUM_RD=4 reading r1..r4 simultaneously -> all rd_busy=1.
